// File: rtl/contador_display_if.sv
// contador_display_if: count/Start request and BCD/7-segment result bundle between counter side and display converter
// Ports (modports): master drives count, Start and observes busy, valid, bcd, seg, an; slave is the converter side.
interface contador_display_if #(
  parameter int BITS = 8,
  parameter int DIGITS = 3
);
  logic [BITS-1:0] count;
  logic Start;
  logic busy;
  logic valid;
  logic [4*DIGITS-1:0] bcd;
  logic [6:0] seg;
  logic [DIGITS-1:0] an;
  modport master (output count, Start, input busy, valid, bcd, seg, an);
  modport slave (input count, Start, output busy, valid, bcd, seg, an);
endinterface

// File: rtl/contador_display.sv
// contador_display: binary count to BCD via sequential double-dabble, shown on a multiplexed 7-segment display
// Ports: NEclk (falling-edge clock), Nreset (async active-low), bus (slave: count, Start in; busy, valid, bcd, seg, an out).
// seg is active-low gfedcba, an is active-low one-hot-zero digit enable.
// Macro CONTADOR_DISPLAY_BLANK_EN: when defined, leading zero digits (never digit 0) are blanked.
module contador_display #(
  parameter int BITS = 8,
  parameter int DIGITS = 3,
  parameter int SCAN_DIV = 4
)(
  input logic NEclk,
  input logic Nreset,
  contador_display_if.slave bus
);
  localparam int W = 4*DIGITS + BITS;
  localparam int CW = $clog2(BITS + 1);
  localparam int DW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction
  if (pow10(DIGITS) <= (64'd1 << BITS)) begin : g_range
    $error("contador_display: DIGITS too small for BITS");
  end
  if (SCAN_DIV < 1) begin : g_div
    $error("contador_display: SCAN_DIV must be at least 1");
  end
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state;
  logic [W-1:0] sh;
  logic [CW-1:0] cnt;
  logic busy, valid;
  logic [4*DIGITS-1:0] bcd;
  logic [DW-1:0] div;
  logic [IW-1:0] idx, nidx;
  logic [DIGITS-1:0] an;
  logic [6:0] seg;
  logic [3:0] nib;
  logic blank;
  // Add 3 to every BCD nibble that is 5 or more, ahead of the shift
  function automatic logic [W-1:0] adj(input logic [W-1:0] v);
    adj = v;
    for (int i = 0; i < DIGITS; i++)
      if (v[BITS+4*i +: 4] >= 4'd5) adj[BITS+4*i +: 4] = v[BITS+4*i +: 4] + 4'd3;
  endfunction
  function automatic logic [6:0] dec(input logic [3:0] d, input logic b);
    if (b) return 7'h7f;
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7f;
    endcase
  endfunction
  always_ff @(negedge NEclk or negedge Nreset)
    if (!Nreset) begin
      state <= IDLE;
      sh <= '0;
      cnt <= '0;
      busy <= 1'b0;
      valid <= 1'b0;
      bcd <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: if (bus.Start) begin
          sh <= {{(4*DIGITS){1'b0}}, bus.count};
          cnt <= '0;
          state <= SHIFT;
          busy <= 1'b1;
        end
        SHIFT: begin
          sh <= adj(sh) << 1;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(BITS - 1)) state <= DONE;
        end
        DONE: begin
          bcd <= sh[W-1:BITS];
          valid <= 1'b1;
          state <= IDLE;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  // an and seg are both derived from the next digit index so they always switch together
  always_comb begin
    nidx = div == DW'(SCAN_DIV - 1) ? (idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1) : idx;
    nib = bcd[4*nidx +: 4];
`ifdef CONTADOR_DISPLAY_BLANK_EN
    blank = nidx != '0 && (bcd >> (4*nidx)) == '0;
`else
    blank = 1'b0;
`endif
  end
  always_ff @(negedge NEclk or negedge Nreset)
    if (!Nreset) begin
      div <= '0;
      idx <= '0;
      an <= ~DIGITS'(1);
      seg <= 7'h40;
    end else begin
      div <= div == DW'(SCAN_DIV - 1) ? '0 : div + 1'b1;
      idx <= nidx;
      an <= ~(DIGITS'(1) << nidx);
      seg <= dec(nib, blank);
    end
  assign bus.busy = busy;
  assign bus.valid = valid;
  assign bus.bcd = bcd;
  assign bus.seg = seg;
  assign bus.an = an;
endmodule

// File: doc/contador_display.md
Name: contador_display

Overview:
- Downstream consumer of the N-bit binary counter; takes its `count` bus and drives a multiplexed 7-segment display.
- Converts the binary value to packed BCD with a sequential shift-add-3 (double-dabble) engine.
- Holds the last converted result and time-multiplexes one digit at a time onto a shared segment bus with rotating digit enables.

Parameters:
- BITS, 8: width of input `count`; must match the feeding counter.
- DIGITS, 3: number of BCD digits and display positions. Elaboration fails with `$error` unless 10^DIGITS > 2^BITS.
- SCAN_DIV, 4: NEclk cycles each digit stays enabled; minimum 1.

Ports:
- NEclk  in  1  clock; all state updates on the falling edge.
- Nreset  in  1  asynchronous, active-low reset.
- count  in  BITS  binary value from counter.
- Start  in  1  request conversion of `count`; sampled only in IDLE.
- busy  out  1  high while the conversion FSM is not IDLE.
- valid  out  1  one-cycle pulse when `bcd` updates.
- bcd  out  4*DIGITS  packed BCD result; digit 0 (units) in [3:0].
- seg  out  7  segments, active-low, bit order gfedcba.
- an  out  DIGITS  digit enables, active-low, one-hot-zero.

Behaviour:
- Reset (Nreset=0, asynchronous, wins over everything):
  - FSM goes to IDLE; shift register and bit counter cleared.
  - busy=0, valid=0, bcd=0.
  - Scan divider=0, digit index=0, an = all ones except bit0 low.
  - seg shows digit 0 of bcd, i.e. '0' = 7'b1000000.
- FSM states: IDLE, SHIFT, DONE. busy = (state != IDLE).
  - IDLE, Start=1 on edge k:
    - Load {DIGITS*4 zeros, count} into the shift register.
    - Clear the bit counter; go to SHIFT.
  - IDLE, Start=0: stay.
  - SHIFT, each edge k+1..k+BITS:
    - Every BCD nibble >=5 gets +3.
    - Then the whole register shifts left by 1.
    - Bit counter increments; after BITS shifts, go to DONE.
  - DONE, edge k+BITS+1:
    - bcd <= BCD half of the shift register.
    - valid=1 for exactly that cycle.
    - Go to IDLE; busy low from that edge.
- Latency: bcd is stable after edge k+BITS+1 (BITS+1 edges after Start is sampled). The next Start is accepted on edge k+BITS+2 at the earliest.
- Start while busy: ignored, not queued. `count` changing during SHIFT/DONE has no effect; the value is captured at edge k.
- Start held high continuously: back-to-back conversions every BITS+2 cycles.
- Reset during SHIFT/DONE: conversion aborted, bcd=0, no valid pulse.
- Display scan (runs independently of the FSM):
  - Divider counts 0..SCAN_DIV-1.
  - At wrap, digit index advances 0→1→…→DIGITS-1→0.
  - an[index]=0, all other an bits 1.
  - seg = decode(bcd nibble[index]), registered on the same edge as an. Enable and segments never mismatch for a cycle.
- Decode table, hex 0-9, active-low gfedcba:
  - 0:40, 1:79, 2:24, 3:30, 4:19
  - 5:12, 6:02, 7:78, 8:00, 9:10
  - Nibbles 10-15 (unreachable) drive 7F (blank).
- bcd changing mid-scan: the next seg update uses the new value; no resync of the scan.

Optional Feature:
- Macro: CONTADOR_DISPLAY_BLANK_EN.
- When defined:
  - Leading zero digits are blanked: seg=7'b1111111 while that digit's an is low.
  - A digit is blanked when it and all more-significant digits are 0.
  - Digit 0 is never blanked; value 0 shows a single '0'.
- When undefined: all digits are always shown, including leading zeros. RTL and ports are otherwise identical.

Test Plan (BITS=8, DIGITS=3, SCAN_DIV=4):
- count=255, Start pulse sampled at edge k:
  - busy rises after k; valid pulses after edge k+9; bcd=12'h255.
  - busy low after k+9.
- count=0, then count=9, then count=128, one Start each:
  - bcd = 12'h000, 12'h009, 12'h128 respectively.
  - Exactly one valid per conversion.
- Start held high with count fixed at 200:
  - valid every 10 cycles; bcd=12'h200 each time.
  - Pulses of Start during busy produce no extra valid.
- Scan with bcd=12'h255 (blank macro undefined):
  - an cycles 110, 101, 011, changing every 4 edges.
  - seg = 12, 12, 24 (hex) for the corresponding digits.
- Nreset asserted between SHIFT edges 3 and 4:
  - All outputs return to reset values immediately, no edge needed; bcd=0, no valid.
  - After release, a new Start with count=37 gives bcd=12'h037.
- With CONTADOR_DISPLAY_BLANK_EN defined and bcd=12'h007:
  - Digits 2 and 1 show seg=7F; digit 0 shows 78.
  - With bcd=0, only digit 0 shows 40.
